// File: rtl/pc_unit_ras.sv
// Fetch-stage PC register with redirect priority mux and a circular
// return-address stack for call/return prediction.
module pc_unit_ras #(
  parameter int               WIDTH        = 32,
  parameter int               RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Stall,
  input  logic                         BranchTaken,
  input  logic [WIDTH-1:0]             BranchTarget,
  input  logic                         Jump,
  input  logic                         Call,
  input  logic [WIDTH-1:0]             JumpTarget,
  input  logic                         Ret,
  output logic [WIDTH-1:0]             PC,
  output logic [WIDTH-1:0]             PCPlus,
  output logic [$clog2(RAS_DEPTH):0]   RasCount,
  output logic                         RasOverflow,
  output logic                         RasUnderflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_top;
  logic [WIDTH-1:0] top;
  logic             empty;
  logic             full;

  logic [WIDTH-1:0] pc_n;
  logic [PW-1:0]    ptr_n;
  logic [CW-1:0]    cnt_n;
  logic             ovf_n;
  logic             unf_n;
  logic             push;
  logic             swap;
  logic             we;
  logic [PW-1:0]    wa;

  assign PCPlus  = PC + WIDTH'(INC);
  assign ptr_top = ptr - PW'(1);
  assign top     = ras[ptr_top];
  assign empty   = (RasCount == '0);
  assign full    = (RasCount == CW'(RAS_DEPTH));

  always_comb begin
    pc_n  = PC;
    ptr_n = ptr;
    cnt_n = RasCount;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    push  = 1'b0;
    swap  = 1'b0;
    if (Stall) begin
      pc_n = PC;
    end else if (BranchTaken) begin
      pc_n = BranchTarget;
    end else if (Ret && !empty) begin
      pc_n = top;
      if (Call) begin
        swap = 1'b1;
      end else begin
        ptr_n = ptr_top;
        cnt_n = RasCount - CW'(1);
      end
    end else if (Ret && !Call) begin
      pc_n  = PCPlus;
      unf_n = 1'b1;
    end else if (Call) begin
      // ptr points at the oldest slot once full, so push overwrites it
      pc_n  = JumpTarget;
      push  = 1'b1;
      ptr_n = ptr + PW'(1);
      unf_n = Ret;
      if (full) ovf_n = 1'b1;
      else      cnt_n = RasCount + CW'(1);
    end else if (Jump) begin
      pc_n = JumpTarget;
    end else begin
      pc_n = PCPlus;
    end
  end

  assign we = push | swap;
  assign wa = swap ? ptr_top : ptr;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      PC           <= RESET_VECTOR;
      ptr          <= '0;
      RasCount     <= '0;
      RasOverflow  <= 1'b0;
      RasUnderflow <= 1'b0;
    end else begin
      PC           <= pc_n;
      ptr          <= ptr_n;
      RasCount     <= cnt_n;
      RasOverflow  <= ovf_n;
      RasUnderflow <= unf_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (we) ras[wa] <= PCPlus;
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed test of pc_unit_ras: reset, wrap, priority, nesting,
// swap, overflow/underflow and asynchronous reset.
module tb_pc_unit_ras;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic        Call;
  logic [31:0] JumpTarget;
  logic        Ret;
  logic [31:0] PC;
  logic [31:0] PCPlus;
  logic [2:0]  RasCount;
  logic        RasOverflow;
  logic        RasUnderflow;

  int n_cmp = 0;
  int n_bad = 0;

  pc_unit_ras #(
    .WIDTH(32), .RAS_DEPTH(4), .RESET_VECTOR(32'h0), .INC(4)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .Call(Call), .JumpTarget(JumpTarget), .Ret(Ret),
    .PC(PC), .PCPlus(PCPlus), .RasCount(RasCount),
    .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    Stall = 0; BranchTaken = 0; Jump = 0; Call = 0; Ret = 0;
  endtask

  task automatic st(input string tag, input logic [31:0] pc,
                    input logic [31:0] cnt, input logic ovf,
                    input logic unf);
    chk({tag, ".pc"}, PC, pc);
    chk({tag, ".cnt"}, 32'(RasCount), cnt);
    chk({tag, ".ovf"}, 32'(RasOverflow), 32'(ovf));
    chk({tag, ".unf"}, 32'(RasUnderflow), 32'(unf));
  endtask

  initial begin
    Rst = 0; idle(); BranchTarget = '0; JumpTarget = '0;
    #3;
    st("rst", 32'h0, 0, 0, 0);
    chk("rst.pcplus", PCPlus, 32'h4);
    #9 Rst = 1;
    tick(); chk("seq1", PC, 32'h4);
    tick(); chk("seq2", PC, 32'h8);
    tick(); chk("seq3", PC, 32'hC);

    Jump = 1; JumpTarget = 32'hFFFF_FFFC;
    tick(); chk("wrap.pc", PC, 32'hFFFF_FFFC);
    chk("wrap.pcplus", PCPlus, 32'h0);
    idle();
    tick(); st("wrap.next", 32'h0, 0, 0, 0);

    Stall = 1; BranchTaken = 1; BranchTarget = 32'h100;
    tick(); st("stall", 32'h0, 0, 0, 0);
    Stall = 0; Ret = 1; Call = 1;
    tick(); st("br_pri", 32'h100, 0, 0, 0);
    idle();

    Jump = 1; JumpTarget = 32'h10;
    tick(); chk("nest.pc0", PC, 32'h10);
    Jump = 0; Call = 1; JumpTarget = 32'h200;
    tick(); st("nest.c1", 32'h200, 1, 0, 0);
    idle();
    tick(); chk("nest.seq", PC, 32'h204);
    Call = 1; JumpTarget = 32'h300;
    tick(); st("nest.c2", 32'h300, 2, 0, 0);
    idle(); Ret = 1;
    tick(); st("nest.r1", 32'h208, 1, 0, 0);
    tick(); st("nest.r2", 32'h14, 0, 0, 0);

    idle(); Call = 1; JumpTarget = 32'h400;
    tick(); st("swap.c", 32'h400, 1, 0, 0);
    Ret = 1; JumpTarget = 32'h480;
    tick(); st("swap.cr", 32'h18, 1, 0, 0);
    Call = 0;
    tick(); st("swap.r", 32'h404, 0, 0, 0);
    Call = 1; JumpTarget = 32'h500;
    tick(); st("cr_empty", 32'h500, 1, 0, 1);
    Call = 0;
    tick(); st("cr_empty.r", 32'h408, 0, 0, 0);

    idle(); Call = 1;
    for (int i = 0; i < 5; i++) begin
      JumpTarget = 32'h1000 * (i + 1);
      tick();
      st($sformatf("ovf.c%0d", i), 32'h1000 * (i + 1),
         (i < 4) ? i + 1 : 4, i == 4, 0);
    end
    idle(); Ret = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      st($sformatf("ovf.r%0d", i), 32'h1000 * (4 - i) + 4, 3 - i, 0, 0);
    end
    tick(); st("unf", 32'h1008, 0, 0, 1);
    idle();
    tick(); st("unf.clr", 32'h100C, 0, 0, 0);

    Call = 1; JumpTarget = 32'h600;
    tick(); chk("ar.c1", 32'(RasCount), 1);
    JumpTarget = 32'h700;
    tick(); st("ar.c2", 32'h700, 2, 0, 0);
    Call = 0; Jump = 1; JumpTarget = 32'h900;
    #2 Rst = 0;
    #1 st("ar.async", 32'h0, 0, 0, 0);
    tick(); st("ar.hold", 32'h0, 0, 0, 0);
    #2 Rst = 1; idle();
    tick(); st("ar.rel", 32'h4, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
